// File: rtl/spi_instruction_sequencer.sv
// Executes SPI-written instructions in the iclk domain: toggle synchroniser,
// opcode decode and a control FSM for soft reset, trigger arming and readout.
module spi_instruction_sequencer #(
    parameter int SYNC_STAGES     = 2,
    parameter int SOFT_RST_CYCLES = 16,
    parameter int READOUT_TIMEOUT = 1024
) (
    input  logic       iclk,
    input  logic       rst,
    input  logic [7:0] instruction,
    input  logic       inst_wr_tgl,
    input  logic [7:0] trigger_channel_mask,
    input  logic [7:0] mode,
    input  logic [7:0] ext_trig,
    input  logic       readout_done,
    output logic       soft_rst,
    output logic       trig_out,
    output logic [7:0] trig_ch,
    output logic       readout_req,
    output logic       busy,
    output logic [7:0] status
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        SOFTRST = 2'b10,
        READOUT = 2'b11
    } state_t;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_SOFT_RST = 8'h01;
    localparam logic [7:0] OP_ARM      = 8'h02;
    localparam logic [7:0] OP_DISARM   = 8'h03;
    localparam logic [7:0] OP_READOUT  = 8'h04;
    localparam logic [7:0] OP_FORCE    = 8'h05;
    localparam logic [7:0] OP_CLEAR    = 8'h06;

    localparam int CNT_MAX = (READOUT_TIMEOUT > SOFT_RST_CYCLES) ? READOUT_TIMEOUT : SOFT_RST_CYCLES;
    localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_tgl_d;
    logic [7:0]             r_opcode;
    logic                   r_cmd_pend;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_trig_cnt;
    logic                   r_err_timeout;
    logic                   r_err_busy;
    logic                   r_err_illegal;
    logic                   r_soft_rst;
    logic                   r_trig_out;
    logic [7:0]             r_trig_ch;
    logic                   r_readout_req;

    logic                   w_cmd_new;
    logic                   w_force;
    logic                   w_illegal;
    logic [7:0]             w_hit;

    assign w_cmd_new = r_sync[SYNC_STAGES-1] ^ r_tgl_d;
    assign w_illegal = (r_opcode > OP_CLEAR);
    // A pending FORCE_TRIGGER in ARMED behaves as if every masked channel fired.
    assign w_force   = r_cmd_pend && (r_opcode == OP_FORCE) && (r_state == ARMED);
    assign w_hit     = (ext_trig | {8{w_force}}) & trigger_channel_mask;

    assign soft_rst    = r_soft_rst;
    assign trig_out    = r_trig_out;
    assign trig_ch     = r_trig_ch;
    assign readout_req = r_readout_req;
    assign busy        = r_state[1];
    assign status      = {r_trig_cnt, r_err_timeout, r_err_busy, r_err_illegal, r_state};

    always_ff @(posedge iclk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_sync        <= '0;
            r_tgl_d       <= 1'b0;
            r_opcode      <= 8'h00;
            r_cmd_pend    <= 1'b0;
            r_cnt         <= '0;
            r_trig_cnt    <= 3'd0;
            r_err_timeout <= 1'b0;
            r_err_busy    <= 1'b0;
            r_err_illegal <= 1'b0;
            r_soft_rst    <= 1'b0;
            r_trig_out    <= 1'b0;
            r_trig_ch     <= 8'h00;
            r_readout_req <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], inst_wr_tgl};
            r_tgl_d    <= r_sync[SYNC_STAGES-1];
            r_trig_out <= 1'b0;

            case (r_state)
                IDLE, ARMED: begin
                    if (r_state == ARMED && w_hit != 8'h00) begin
                        // Trigger wins; a non-force command stays pending for next cycle.
                        r_trig_out <= 1'b1;
                        r_trig_ch  <= w_hit;
                        if (r_trig_cnt != 3'd7) r_trig_cnt <= r_trig_cnt + 3'd1;
                        if (!mode[0]) r_state <= IDLE;
                        if (w_force) r_cmd_pend <= 1'b0;
                    end else if (r_cmd_pend) begin
                        r_cmd_pend <= 1'b0;
                        if (r_opcode == OP_SOFT_RST) begin
                            r_state    <= SOFTRST;
                            r_soft_rst <= 1'b1;
                            r_cnt      <= '0;
                            r_trig_cnt <= 3'd0;
                        end else if (r_opcode == OP_ARM && r_state == IDLE) begin
                            r_state    <= ARMED;
                            r_trig_cnt <= 3'd0;
                        end else if (r_opcode == OP_DISARM && r_state == ARMED) begin
                            r_state <= IDLE;
                        end else if (r_opcode == OP_READOUT && r_state == IDLE) begin
                            r_state       <= READOUT;
                            r_readout_req <= 1'b1;
                            r_cnt         <= '0;
                        end else if (r_opcode == OP_CLEAR) begin
                            r_err_timeout <= 1'b0;
                            r_err_busy    <= 1'b0;
                            r_err_illegal <= 1'b0;
                        end else if (w_illegal) begin
                            r_err_illegal <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (r_state == SOFTRST) begin
                        if (r_cnt == CW'(SOFT_RST_CYCLES - 1)) begin
                            r_soft_rst <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (readout_done) begin
                        r_readout_req <= 1'b0;
                        r_state       <= IDLE;
                    end else if (r_cnt == CW'(READOUT_TIMEOUT - 1)) begin
                        r_readout_req <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (r_cmd_pend) begin
                        r_cmd_pend <= 1'b0;
                        if (r_opcode == OP_CLEAR) begin
                            r_err_timeout <= 1'b0;
                            r_err_busy    <= 1'b0;
                            r_err_illegal <= 1'b0;
                        end else if (w_illegal) begin
                            r_err_illegal <= 1'b1;
                        end else if (r_opcode != OP_NOP) begin
                            r_err_busy <= 1'b1;
                        end
                    end
                end
            endcase

            if (w_cmd_new) begin
                r_opcode   <= instruction;
                r_cmd_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_instruction_sequencer.sv
// Directed bench for spi_instruction_sequencer: each step drives inputs and
// checks outputs #1 after the rising edge against hand-computed values.
module tb_spi_instruction_sequencer;

    logic       iclk = 1'b0;
    logic       rst;
    logic [7:0] instruction;
    logic       inst_wr_tgl;
    logic [7:0] trigger_channel_mask;
    logic [7:0] mode;
    logic [7:0] ext_trig;
    logic       readout_done;
    logic       soft_rst;
    logic       trig_out;
    logic [7:0] trig_ch;
    logic       readout_req;
    logic       busy;
    logic [7:0] status;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    spi_instruction_sequencer #(
        .SYNC_STAGES(2), .SOFT_RST_CYCLES(16), .READOUT_TIMEOUT(1024)
    ) dut (
        .iclk(iclk), .rst(rst), .instruction(instruction), .inst_wr_tgl(inst_wr_tgl),
        .trigger_channel_mask(trigger_channel_mask), .mode(mode), .ext_trig(ext_trig),
        .readout_done(readout_done), .soft_rst(soft_rst), .trig_out(trig_out),
        .trig_ch(trig_ch), .readout_req(readout_req), .busy(busy), .status(status)
    );

    always #5 iclk = ~iclk;

    task automatic step(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue an instruction write; the effect is visible after the 4th edge.
    task automatic send(input logic [7:0] op);
        instruction = op;
        inst_wr_tgl = ~inst_wr_tgl;
        step(4);
    endtask

    initial begin
        rst = 1'b1; instruction = 8'h00; inst_wr_tgl = 1'b0;
        trigger_channel_mask = 8'h00; mode = 8'h00; ext_trig = 8'h00; readout_done = 1'b0;
        step(3);
        chk("reset_status", status, 8'h00);
        chk("reset_outs", {soft_rst, trig_out, readout_req, busy}, 8'h00);
        chk("reset_trig_ch", trig_ch, 8'h00);
        rst = 1'b0;
        step(2);

        send(8'h00);
        chk("nop_status", status, 8'h00);

        // Soft reset: rises on the 4th edge, high exactly 16 cycles.
        instruction = 8'h01;
        inst_wr_tgl = ~inst_wr_tgl;
        step(3);
        chk("srst_not_yet", soft_rst, 1'b0);
        step(1);
        chk("srst_rise", soft_rst, 1'b1);
        chk("srst_status", status, 8'h02);
        chk("srst_busy", busy, 1'b1);
        step(15);
        chk("srst_still_high", soft_rst, 1'b1);
        step(1);
        chk("srst_fall", soft_rst, 1'b0);
        chk("srst_done_status", status, 8'h00);

        // ARM during the pulse is dropped as busy.
        send(8'h01);
        send(8'h02);
        chk("busy_err_status", status, 8'h0A);
        step(11);
        chk("busy_srst_high", soft_rst, 1'b1);
        step(1);
        chk("busy_srst_fall", soft_rst, 1'b0);
        chk("busy_err_idle", status, 8'h08);
        send(8'h06);
        chk("clear_status", status, 8'h00);

        // Single-shot arm
        trigger_channel_mask = 8'h0A; mode = 8'h00;
        send(8'h02);
        chk("arm_status", status, 8'h01);
        ext_trig = 8'h0F;
        step(1);
        ext_trig = 8'h00;
        chk("ss_trig_out", trig_out, 1'b1);
        chk("ss_trig_ch", trig_ch, 8'h0A);
        chk("ss_status", status, 8'h20);
        step(1);
        chk("ss_trig_out_low", trig_out, 1'b0);
        send(8'h02);
        chk("rearm_status", status, 8'h01);
        ext_trig = 8'h05;
        step(1);
        ext_trig = 8'h00;
        chk("masked_no_trig", trig_out, 1'b0);
        chk("masked_status", status, 8'h01);
        send(8'h05);
        chk("force_trig_out", trig_out, 1'b1);
        chk("force_trig_ch", trig_ch, 8'h0A);
        chk("force_status", status, 8'h20);
        send(8'h03);
        chk("disarm_idle_nop", status, 8'h20);

        // Continuous mode: 9 back-to-back triggers, count saturates.
        mode = 8'h01;
        send(8'h02);
        chk("cont_arm_status", status, 8'h01);
        pulses = 0;
        ext_trig = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            step(1);
            if (trig_out) pulses++;
        end
        ext_trig = 8'h00;
        chk("cont_pulses", 8'(pulses), 8'd9);
        chk("cont_trig_ch", trig_ch, 8'h0A);
        chk("cont_status", status, 8'hE1);
        send(8'h03);
        chk("cont_disarm", status, 8'hE0);
        send(8'h01);
        step(16);
        chk("srst_clears_cnt", status, 8'h00);
        mode = 8'h00;

        // Readout timeout
        send(8'h04);
        chk("ro_req_rise", readout_req, 1'b1);
        chk("ro_status", status, 8'h03);
        step(1023);
        chk("ro_req_last", readout_req, 1'b1);
        step(1);
        chk("ro_req_timeout", readout_req, 1'b0);
        chk("ro_timeout_status", status, 8'h10);
        send(8'h06);
        chk("ro_clear", status, 8'h00);

        // Done on the timeout cycle wins.
        send(8'h04);
        step(1023);
        chk("ro2_req_last", readout_req, 1'b1);
        readout_done = 1'b1;
        step(1);
        readout_done = 1'b0;
        chk("ro2_req_done", readout_req, 1'b0);
        chk("ro2_status", status, 8'h00);

        // Illegal opcode, then async reset mid-readout and mid-soft-reset.
        send(8'hA5);
        chk("illegal_status", status, 8'h04);
        send(8'h04);
        chk("ill_ro_status", status, 8'h07);
        step(10);
        rst = 1'b1;
        #1;
        chk("async_ro_req", readout_req, 1'b0);
        chk("async_ro_status", status, 8'h00);
        step(1);
        rst = 1'b0;
        step(2);
        send(8'h01);
        step(5);
        chk("srst_mid_high", soft_rst, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_srst", soft_rst, 1'b0);
        chk("async_srst_status", status, 8'h00);
        step(1);
        rst = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_instruction_sequencer.md
Name: spi_instruction_sequencer

Overview:
- Consumes the instruction, trigger_channel_mask and mode bytes written over SPI. Executes each newly written instruction in the internal clock domain.
- Synchronises the SPI-domain write strobe, decodes the opcode and runs a small control FSM (soft reset, trigger arming, readout handshake).
- Produces a status byte that the SPI read path returns to the host.

Parameters:
- SYNC_STAGES, 2, flops in the inst_wr_tgl synchroniser (min 2).
- SOFT_RST_CYCLES, 16, width of the soft_rst pulse in iclk cycles (1..255).
- READOUT_TIMEOUT, 1024, iclk cycles to wait for readout_done before abort (≥2).

Ports:
- iclk  in  1  internal clock; all logic on posedge.
- rst  in  1  asynchronous active-high reset, clocked on iclk.
- instruction  in  8  opcode from SPI address 2; quasi-static, stable ≥1 cycle before the toggle is seen.
- inst_wr_tgl  in  1  SPI-domain toggle; flips once per write to address 2.
- trigger_channel_mask  in  8  channel enable mask (SPI address 1).
- mode  in  8  bit0: 1 = continuous arm, 0 = single-shot; other bits ignored.
- ext_trig  in  8  per-channel discriminator hits, iclk-synchronous.
- readout_done  in  1  1-cycle pulse from the readout engine.
- soft_rst  out  1  active-high soft reset to analog/counter logic.
- trig_out  out  1  1-cycle pulse on an accepted trigger.
- trig_ch  out  8  ext_trig & mask captured at the last accepted trigger.
- readout_req  out  1  level; held until done or timeout.
- busy  out  1  high in any state other than IDLE or ARMED.
- status  out  8  {trig_cnt[2:0], err_timeout, err_busy, err_illegal, state[1:0]}.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE(2'b00); all outputs 0; sticky errors 0; trig_cnt 0; sync flops 0.
- Strobe detection:
  - inst_wr_tgl passes through SYNC_STAGES flops, then one edge-detect flop.
  - cmd_new asserts for 1 cycle on any change. With SYNC_STAGES=2, cmd_new is high in the 3rd rising iclk edge after the toggle.
  - instruction is registered into opcode on the cmd_new cycle.
  - The action begins on the next cycle: 1-cycle decode latency, 4 cycles total from toggle to effect.
- States: IDLE=00, ARMED=01, SOFTRST=10, READOUT=11.
- Opcodes, per state:
  - 0x00 NOP: no effect in any state.
  - 0x01 SOFT_RESET: IDLE/ARMED → SOFTRST. soft_rst=1 for exactly SOFT_RST_CYCLES cycles, then → IDLE. Also clears trig_cnt.
  - 0x02 ARM: IDLE → ARMED. trig_cnt cleared on entry. In ARMED it is a no-op.
  - 0x03 DISARM: ARMED → IDLE. In IDLE it is a no-op.
  - 0x04 START_READOUT: IDLE → READOUT; readout_req=1 from the entry cycle.
  - 0x05 FORCE_TRIGGER: in ARMED, acts as ext_trig=mask for that cycle. In IDLE it is a no-op.
  - 0x06 CLEAR_STATUS: clears err_illegal, err_busy and err_timeout. Accepted in every state; does not change state.
  - Any other value: sets err_illegal; no state change. Applies in all states.
- Busy handling: any opcode other than 0x00 or 0x06 arriving in SOFTRST or READOUT is dropped and sets err_busy.
- ARMED trigger:
  - hit = ext_trig & trigger_channel_mask. A zero mask means never trigger.
  - On a cycle with hit≠0: trig_out=1 next cycle, trig_ch<=hit, and trig_cnt increments, saturating at 7.
  - Then: mode[0]=0 → IDLE; mode[0]=1 → stay ARMED.
  - Triggers on back-to-back cycles in continuous mode each produce a pulse.
- READOUT:
  - readout_done → readout_req=0, → IDLE on the next cycle.
  - The timeout counter starts at 0 on entry. At READOUT_TIMEOUT cycles without done: readout_req=0, err_timeout=1, → IDLE.
  - done on the same cycle as timeout: done wins, no error.
  - readout_done outside READOUT is ignored.
- Simultaneous events:
  - cmd_new and a trigger in ARMED on the same cycle: the trigger is processed; the command takes effect next cycle against the resulting state.
  - Two toggles closer than SYNC_STAGES+1 cycles are unsupported; the SPI protocol guarantees ≥8 sclk between writes.
- Mid-operation reset: rst in any state aborts immediately (async). soft_rst, readout_req and trig_out drop the same instant.
- Errors are sticky until CLEAR_STATUS or rst.

Test Plan:
- Reset then idle: rst pulse → status=0x00, all outputs 0; flipping inst_wr_tgl with instruction=0x00 → status stays 0x00.
- Soft reset: instruction=0x01, toggle → soft_rst rises 4 cycles after the toggle, stays high exactly 16 cycles, status returns 0x00; a 0x02 issued mid-pulse → status bit3=1.
- Single-shot arm: mask=0x0A, mode=0x00, ARM, ext_trig=0x0F for 1 cycle → trig_out one pulse, trig_ch=0x0A, status=0x20 (cnt=1, IDLE); ext_trig=0x05 while armed → no trigger.
- Continuous mode: mode=0x01, ARM, 9 triggers → 9 trig_out pulses, trig_cnt saturates, status=0xE1.
- Readout timeout: START_READOUT with no readout_done → readout_req high 1024 cycles then low, status=0x10; CLEAR_STATUS → 0x00; repeat with done at cycle 1024 → status=0x00.
- Illegal opcode and async reset: instruction=0xA5 → status=0x04; START_READOUT then rst mid-READOUT → readout_req=0 asynchronously, status=0x00.
